// File: rtl/elastic_pipe_pkg.sv
// Shared definitions for the elastic pipeline register chain:
// slot occupancy encoding and the all-zero NOP control word.
package elastic_pipe_pkg;

    // Bit 0 = main register valid, bit 1 = skid register valid.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'b00,
        SLOT_ONE   = 2'b01,
        SLOT_TWO   = 2'b11
    } slot_state_e;

    localparam logic [63:0] NOP_CTRL = 64'h0;

endpackage

// File: rtl/elastic_pipe_slot.sv
// One main/skid slot of the elastic chain. Ready depends only on local
// state, so no combinational path runs from out_ready to in_ready.
module elastic_pipe_slot
    import elastic_pipe_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int CTRL_WIDTH          = 8,
    parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [CTRL_WIDTH-1:0] NOP = NOP_CTRL[CTRL_WIDTH-1:0];

    slot_state_e           state_q, state_d;
    logic                  ready_q, ready_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic                  push_s, pop_s;

    assign push_s = in_valid & ready_q;
    assign pop_s  = state_q[0] & out_ready;

    // Next-state: flush wins; any register that empties reloads the NOP ctrl.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = SLOT_EMPTY;
            main_ctrl_d = NOP;
            skid_ctrl_d = NOP;
            if (CLEAR_DATA_ON_FLUSH) begin
                main_data_d = {DATA_WIDTH{1'b0}};
                skid_data_d = {DATA_WIDTH{1'b0}};
            end else begin
                main_data_d = main_data_q;
                skid_data_d = skid_data_q;
            end
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (push_s) begin
                        state_d     = SLOT_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else begin
                        state_d = SLOT_EMPTY;
                    end
                end
                SLOT_ONE: begin
                    if (push_s && pop_s) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (push_s) begin
                        state_d     = SLOT_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (pop_s) begin
                        state_d     = SLOT_EMPTY;
                        main_ctrl_d = NOP;
                    end else begin
                        state_d = SLOT_ONE;
                    end
                end
                SLOT_TWO: begin
                    if (pop_s) begin
                        state_d     = SLOT_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = NOP;
                    end else begin
                        state_d = SLOT_TWO;
                    end
                end
                default: begin
                    state_d     = SLOT_EMPTY;
                    main_ctrl_d = NOP;
                    skid_ctrl_d = NOP;
                end
            endcase
        end
        ready_d = ~state_d[1];
    end

    // Slot registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SLOT_EMPTY;
            ready_q     <= 1'b1;
            main_ctrl_q <= {CTRL_WIDTH{1'b0}};
            main_data_q <= {DATA_WIDTH{1'b0}};
            skid_ctrl_q <= {CTRL_WIDTH{1'b0}};
            skid_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = state_q[0];
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/elastic_pipe_stage.sv
// Elastic pipeline register chain of STAGES main/skid slots with a
// registered occupancy count of all entries held.
module elastic_pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int CTRL_WIDTH          = 8,
    parameter int STAGES              = 1,
    parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
    parameter int CNT_WIDTH           = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  occupancy
);

    // Index k is the input side of slot k; index STAGES is the chain output.
    logic [STAGES:0]                 vld_s;
    logic [STAGES:0]                 rdy_s;
    logic [STAGES:0][CTRL_WIDTH-1:0] ctrl_s;
    logic [STAGES:0][DATA_WIDTH-1:0] data_s;
    logic [CNT_WIDTH-1:0]            occ_q, occ_d;
    logic                            push_s, pop_s;

    assign vld_s[0]      = in_valid;
    assign ctrl_s[0]     = in_ctrl;
    assign data_s[0]     = in_data;
    assign rdy_s[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        elastic_pipe_slot #(
            .DATA_WIDTH          (DATA_WIDTH),
            .CTRL_WIDTH          (CTRL_WIDTH),
            .CLEAR_DATA_ON_FLUSH (CLEAR_DATA_ON_FLUSH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (vld_s[k]),
            .in_ready  (rdy_s[k]),
            .in_ctrl   (ctrl_s[k]),
            .in_data   (data_s[k]),
            .out_valid (vld_s[k+1]),
            .out_ready (rdy_s[k+1]),
            .out_ctrl  (ctrl_s[k+1]),
            .out_data  (data_s[k+1])
        );
    end

    // Internal slot-to-slot moves leave the total unchanged; only the ends count.
    assign push_s = in_valid & rdy_s[0];
    assign pop_s  = vld_s[STAGES] & out_ready;

    // Occupancy next value.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = {CNT_WIDTH{1'b0}};
        end else if (push_s && !pop_s) begin
            occ_d = occ_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_s) begin
            occ_d = occ_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= {CNT_WIDTH{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = vld_s[STAGES];
    assign out_ctrl  = ctrl_s[STAGES];
    assign out_data  = data_s[STAGES];
    assign occupancy = occ_q;

endmodule
